// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
package axis_fifo_pkg;

  typedef enum logic {ST_HOLD, ST_RELEASE} pkt_state_t;

  // Pointers are AW = $clog2(DEPTH) address bits plus one wrap bit.
  localparam int unsigned PTR_EXTRA_W = 1;
  localparam int unsigned MAX_PTR_W   = 32;

  // Full when the address bits match and the wrap bits differ.
  function automatic logic ptr_full(input logic [MAX_PTR_W-1:0] wptr,
                                    input logic [MAX_PTR_W-1:0] rptr,
                                    input int unsigned          aw);
    logic [MAX_PTR_W-1:0] diff;
    diff = (wptr ^ rptr) & ((MAX_PTR_W'(2) << aw) - MAX_PTR_W'(1));
    return diff == (MAX_PTR_W'(1) << aw);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with first-word fall-through, level flags and
// optional store-and-forward packet mode with an oversize-packet escape.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned PKT_MODE  = 0,
  parameter int unsigned AFULL_TH  = DEPTH - 4,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic                     ref_clk,
  input  logic                     i_rst_n,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_afull,
  output logic                     o_aempty,
  output logic                     o_oversize
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PW       = AW + PTR_EXTRA_W;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);
  localparam bit            PKT      = (PKT_MODE != 0);

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d, pkt_cnt_q, pkt_cnt_d;
  logic          ready_q, ready_d, afull_q, afull_d;
  logic          aempty_q, aempty_d, oversize_q, oversize_d;
  pkt_state_t    state_q, state_d;

  logic              empty_c, full_c, wr_c, rd_c, vld_c, head_last_c;
  logic [DATA_W-1:0] head_data_c;
  logic [DATA_W:0]   head_c;

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1),
    .AW    (AW)
  ) u_ram (
    .clk     (ref_clk),
    .we      (wr_c),
    .waddr   (wptr_q[AW-1:0]),
    .wdata   ({s_axis_tlast, s_axis_tdata}),
    .raddr   (rptr_q[AW-1:0]),
    .rdata_c (head_c)
  );

  assign {head_last_c, head_data_c} = head_c;
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = ptr_full(MAX_PTR_W'(wptr_q), MAX_PTR_W'(rptr_q), AW);
  assign wr_c    = s_axis_tvalid & ready_q;
  assign rd_c    = vld_c & m_axis_tready;

  // In packet mode the head is withheld until a whole packet is stored.
  always_comb begin
    vld_c = !empty_c;
    if (PKT && (state_q == ST_HOLD)) vld_c = !empty_c && (pkt_cnt_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    oversize_d = oversize_q;
    count_d    = count_q;
    pkt_cnt_d  = pkt_cnt_q;
    wptr_d     = wptr_q + PW'(wr_c);
    rptr_d     = rptr_q + PW'(rd_c);

    case ({wr_c, rd_c})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    case ({wr_c & s_axis_tlast, rd_c & head_last_c})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // Full with no complete packet would deadlock; stream it out instead.
    case (state_q)
      ST_HOLD: begin
        if (PKT && full_c && (pkt_cnt_q == '0)) begin
          state_d    = ST_RELEASE;
          oversize_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (rd_c && head_last_c) state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase

    ready_d  = !ptr_full(MAX_PTR_W'(wptr_d), MAX_PTR_W'(rptr_d), AW);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge ref_clk) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      ready_q    <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      oversize_q <= 1'b0;
      state_q    <= ST_HOLD;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ready_q    <= ready_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      oversize_q <= oversize_d;
      state_q    <= state_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = vld_c;
  assign m_axis_tdata  = head_data_c;
  assign m_axis_tlast  = head_last_c;
  assign o_count       = count_q;
  assign o_afull       = afull_q;
  assign o_aempty      = aempty_q;
  assign o_oversize    = oversize_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench: instance 0 is cut-through, instance 1 is packet mode, both DEPTH=8.
module tb_axis_pkt_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned AFT   = 6;
  localparam int unsigned AET   = 2;

  logic ref_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 ref_clk = ~ref_clk;

  logic [1:0][DW-1:0] s_tdata, m_tdata;
  logic [1:0][CW-1:0] count;
  logic [1:0] s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
  logic [1:0] afull, aempty, ovs;

  int checks = 0;
  int errors = 0;

  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  bit skip0 = 1'b1, skip1 = 1'b1;
  bit rel1 = 1'b0, ovs1 = 1'b0;

  axis_pkt_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(0), .AFULL_TH(AFT), .AEMPTY_TH(AET)
  ) u_dut0 (
    .ref_clk(ref_clk), .i_rst_n(i_rst_n),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]),
    .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tready(m_tready[0]),
    .o_count(count[0]), .o_afull(afull[0]), .o_aempty(aempty[0]), .o_oversize(ovs[0])
  );

  axis_pkt_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(1), .AFULL_TH(AFT), .AEMPTY_TH(AET)
  ) u_dut1 (
    .ref_clk(ref_clk), .i_rst_n(i_rst_n),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]),
    .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tready(m_tready[1]),
    .o_count(count[1]), .o_afull(afull[1]), .o_aempty(aempty[1]), .o_oversize(ovs[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cut-through model: a plain ordered queue of {tlast, tdata}.
  always @(negedge ref_clk) begin
    logic [DW:0] e;
    if (!i_rst_n) begin
      q0.delete();
      skip0 = 1'b1;
    end else begin
      chk("count0", 32'(count[0]), 32'(q0.size()));
      chk("afull0", 32'(afull[0]), 32'(q0.size() >= AFT));
      chk("aempty0", 32'(aempty[0]), 32'(q0.size() <= AET));
      chk("ovs0", 32'(ovs[0]), 32'(0));
      if (!skip0) chk("tready0", 32'(s_tready[0]), 32'(q0.size() < DEPTH));
      chk("tvalid0", 32'(m_tvalid[0]), 32'(q0.size() != 0));
      if (m_tvalid[0] && m_tready[0] && q0.size() != 0) begin
        e = q0.pop_front();
        chk("data0", 32'(m_tdata[0]), 32'(e[DW-1:0]));
        chk("last0", 32'(m_tlast[0]), 32'(e[DW]));
      end
      if (s_tvalid[0] && s_tready[0]) q0.push_back({s_tlast[0], s_tdata[0]});
      skip0 = 1'b0;
    end
  end

  // Packet model: readable once the queue holds a tlast, or while an oversize packet drains.
  always @(negedge ref_clk) begin
    logic [DW:0] e;
    bit hl, rset, rclr;
    if (!i_rst_n) begin
      q1.delete();
      skip1 = 1'b1;
      rel1  = 1'b0;
      ovs1  = 1'b0;
    end else begin
      hl = 1'b0;
      foreach (q1[i]) if (q1[i][DW]) hl = 1'b1;
      chk("count1", 32'(count[1]), 32'(q1.size()));
      chk("afull1", 32'(afull[1]), 32'(q1.size() >= AFT));
      chk("aempty1", 32'(aempty[1]), 32'(q1.size() <= AET));
      chk("ovs1", 32'(ovs[1]), 32'(ovs1));
      if (!skip1) chk("tready1", 32'(s_tready[1]), 32'(q1.size() < DEPTH));
      chk("tvalid1", 32'(m_tvalid[1]), 32'((q1.size() != 0) && (rel1 || hl)));
      rset = !rel1 && (q1.size() == DEPTH) && !hl;
      rclr = 1'b0;
      if (m_tvalid[1] && m_tready[1] && q1.size() != 0) begin
        e = q1.pop_front();
        chk("data1", 32'(m_tdata[1]), 32'(e[DW-1:0]));
        chk("last1", 32'(m_tlast[1]), 32'(e[DW]));
        if (rel1 && e[DW]) rclr = 1'b1;
      end
      if (s_tvalid[1] && s_tready[1]) q1.push_back({s_tlast[1], s_tdata[1]});
      if (rset) begin
        rel1 = 1'b1;
        ovs1 = 1'b1;
      end else if (rclr) begin
        rel1 = 1'b0;
      end
      skip1 = 1'b0;
    end
  end

  task automatic send(input int k, input logic [DW-1:0] d, input logic last);
    int n;
    n = 0;
    s_tdata[k]  = d;
    s_tlast[k]  = last;
    s_tvalid[k] = 1'b1;
    @(negedge ref_clk);
    while (!s_tready[k] && n < 200) begin
      @(negedge ref_clk);
      n++;
    end
    if (!s_tready[k]) chk($sformatf("send_timeout%0d", k), 32'(s_tready[k]), 32'(1));
    @(posedge ref_clk);
    #1;
    s_tvalid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    m_tready[k] = 1'b1;
    @(negedge ref_clk);
    while (count[k] != 0 && n < 300) begin
      @(negedge ref_clk);
      n++;
    end
    chk($sformatf("drain%0d", k), 32'(count[k]), 32'(0));
    @(posedge ref_clk);
    #1;
    m_tready[k] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge ref_clk);
    #1;
    i_rst_n = 1'b0;
    repeat (cycles) @(posedge ref_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int nw, rem;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = '0;

    // Reset values and tready rising one cycle after release
    repeat (2) @(posedge ref_clk);
    #1;
    @(negedge ref_clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_tvalid%0d", k), 32'(m_tvalid[k]), 32'(0));
      chk($sformatf("rst_count%0d", k), 32'(count[k]), 32'(0));
      chk($sformatf("rst_aempty%0d", k), 32'(aempty[k]), 32'(1));
      chk($sformatf("rst_afull%0d", k), 32'(afull[k]), 32'(0));
      chk($sformatf("rst_tready%0d", k), 32'(s_tready[k]), 32'(0));
      chk($sformatf("rst_ovs%0d", k), 32'(ovs[k]), 32'(0));
    end
    @(posedge ref_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge ref_clk);
    chk("rel_tready0_low", 32'(s_tready[0]), 32'(0));
    @(posedge ref_clk);
    #1;
    chk("rel_tready0_high", 32'(s_tready[0]), 32'(1));
    chk("rel_tready1_high", 32'(s_tready[1]), 32'(1));

    // Fill to full with no reads, then drain in order
    for (int i = 1; i <= 8; i++) send(0, DW'(i), 1'b0);
    @(negedge ref_clk);
    chk("full_tready", 32'(s_tready[0]), 32'(0));
    chk("full_count", 32'(count[0]), 32'(8));
    chk("full_afull", 32'(afull[0]), 32'(1));
    drain(0);
    chk("empty_aempty", 32'(aempty[0]), 32'(1));

    // Reset with five words stored: contents must vanish
    for (int i = 0; i < 5; i++) send(0, DW'(16'hA0 + i), 1'b0);
    @(negedge ref_clk);
    chk("mid_count_pre", 32'(count[0]), 32'(5));
    do_reset(2);
    @(negedge ref_clk);
    chk("mid_count_post", 32'(count[0]), 32'(0));
    chk("mid_tvalid_post", 32'(m_tvalid[0]), 32'(0));
    m_tready[0] = 1'b1;
    repeat (3) @(posedge ref_clk);
    #1;
    m_tready[0] = 1'b0;

    // Concurrent read and write at count 4
    for (int i = 0; i < 4; i++) send(0, DW'(16'h100 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      s_tdata[0]  = DW'(16'h200 + i);
      s_tlast[0]  = 1'(i % 3 == 0);
      s_tvalid[0] = 1'b1;
      m_tready[0] = 1'b1;
      @(negedge ref_clk);
      chk("simul_count", 32'(count[0]), 32'(4));
      @(posedge ref_clk);
      #1;
    end
    s_tvalid[0] = 1'b0;
    drain(0);

    // Random traffic with wrap-around
    nw = 0;
    for (int c = 0; c < 6000 && nw < 1000; c++) begin
      s_tvalid[0] = ($urandom_range(2, 0) != 0);
      s_tdata[0]  = DW'($urandom);
      s_tlast[0]  = 1'($urandom_range(1, 0));
      m_tready[0] = 1'($urandom_range(1, 0));
      @(negedge ref_clk);
      if (s_tvalid[0] && s_tready[0]) nw++;
      @(posedge ref_clk);
      #1;
    end
    chk("rand_words0", 32'(nw), 32'(1000));
    s_tvalid[0] = 1'b0;
    drain(0);

    // Packet mode: head withheld until tlast is stored
    send(1, 16'h11, 1'b0);
    @(negedge ref_clk);
    chk("pkt_hold_w1", 32'(m_tvalid[1]), 32'(0));
    send(1, 16'h12, 1'b0);
    @(negedge ref_clk);
    chk("pkt_hold_w2", 32'(m_tvalid[1]), 32'(0));
    send(1, 16'h13, 1'b1);
    @(negedge ref_clk);
    chk("pkt_avail_w3", 32'(m_tvalid[1]), 32'(1));
    drain(1);

    // Oversize packet: 12 words through an 8-deep FIFO
    m_tready[1] = 1'b1;
    for (int i = 0; i < 12; i++) send(1, DW'(16'h300 + i), 1'(i == 11));
    drain(1);
    chk("ovs_set", 32'(ovs[1]), 32'(1));
    m_tready[1] = 1'b1;
    send(1, 16'h400, 1'b0);
    send(1, 16'h401, 1'b0);
    repeat (3) @(negedge ref_clk);
    chk("back_to_hold", 32'(m_tvalid[1]), 32'(0));
    chk("hold_count", 32'(count[1]), 32'(2));
    chk("ovs_sticky", 32'(ovs[1]), 32'(1));
    send(1, 16'h402, 1'b1);
    drain(1);

    // Random packets of 1..12 words in packet mode
    rem = 0;
    for (int c = 0; (c < 1500 || rem != 0) && c < 4000; c++) begin
      if (rem == 0) rem = int'($urandom_range(12, 1));
      s_tvalid[1] = ($urandom_range(3, 0) != 0);
      s_tdata[1]  = DW'($urandom);
      s_tlast[1]  = (rem == 1);
      m_tready[1] = 1'($urandom_range(1, 0));
      @(negedge ref_clk);
      if (s_tvalid[1] && s_tready[1]) rem--;
      @(posedge ref_clk);
      #1;
    end
    chk("rand_pkt_complete", 32'(rem), 32'(0));
    s_tvalid[1] = 1'b0;
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
